motor_ramp_ctrl: RTL and testbench
==================================

Name: motor_ramp_ctrl

Overview:
Speed sequencer that sits between the IR NEC decoder and the PWM generator in the remote-motor design.
- Validates decoded key frames and keeps an on/off state and a target duty.
- Slews the duty value sent to the PWM (rate_set) one step at a time for soft start, soft stop and smooth speed changes.
- Drives the motor enable (sw) so the output is gated only after the ramp-down reaches zero.

Parameters:
KEY_ONOFF, 8'h45, command byte for the on/off toggle key
KEY_UP, 8'h46, command byte for the speed-up key
KEY_DOWN, 8'h47, command byte for the speed-down key
RATE_MIN, 10, lowest running duty (%) and soft-start entry point
RATE_MAX, 100, highest duty (%)
RATE_INIT, 50, target duty after reset
STEP, 10, target change per up/down key
RAMP_DIV, 100, tick_en pulses between successive 1 % ramp steps (range 1..1023)
TIMEOUT_TICKS, 600000, tick_en pulses of key inactivity before auto-stop (optional feature only)

Ports:
CLK  in  1  system clock; one clock domain
RST  in  1  reset, synchronous, active-high
tick_en  in  1  one-CLK-wide timebase pulse (e.g. 10 kHz)
key_valid  in  1  one-CLK pulse; data_in holds a freshly decoded frame
data_in  in  32  decoded NEC frame; [15:8] command, [7:0] bitwise complement of command
rate_set  out  7  duty to PWM, 0..RATE_MAX
sw  out  1  motor enable
busy  out  1  high while ramping (RAMP_UP or RAMP_DOWN)
state  out  2  00 OFF, 01 RAMP_UP, 10 RUN, 11 RAMP_DOWN

Behaviour:
Reset (RST high at a CLK edge; overrides everything, including a mid-ramp):
- rate_set=0, sw=0, busy=0, state=OFF, target=RATE_INIT, ramp counter=0.

Frame acceptance:
- A key is accepted only when key_valid=1 and data_in[7:0]==~data_in[15:8].
- A failed check or an unknown command byte is ignored with no state change.
- Accepted keys update state and target at the next CLK edge (1-cycle latency).

Ramp engine:
- The counter increments on tick_en while state is RAMP_UP or RAMP_DOWN, and is held at 0 otherwise.
- When the counter reaches RAMP_DIV-1 with tick_en=1, it returns to 0 and rate_set moves 1 toward the goal.
- Goal is target in RAMP_UP and 0 in RAMP_DOWN.
- All comparisons use register values from the start of the cycle. A target change in the same cycle as a step applies from the next step.

State transitions:
- OFF + ONOFF -> RAMP_UP: sw=1, rate_set=RATE_MIN, target unchanged.
- RAMP_UP -> RUN when rate_set==target.
- RAMP_UP or RUN + ONOFF -> RAMP_DOWN. sw stays 1.
- RAMP_DOWN -> OFF in the cycle after rate_set reaches 0: sw=0 at the same edge.
- RAMP_DOWN + ONOFF -> RAMP_UP, continuing from the current rate_set.
- RUN + UP/DOWN -> RAMP_UP (slew toward the new target in either direction) when the target changes. If the target is already saturated, stay in RUN.
- UP/DOWN in RAMP_UP update the target and stay in RAMP_UP.
- UP/DOWN in OFF or RAMP_DOWN are ignored.

Arithmetic:
- target±STEP is computed at 8 bits and saturates to [RATE_MIN, RATE_MAX].
- rate_set never exceeds RATE_MAX, never wraps, and never goes below 0.
- When sw=1 and state≠RAMP_DOWN, rate_set ≥ RATE_MIN.

Outputs:
- busy = (state==RAMP_UP)||(state==RAMP_DOWN).
- All outputs are registered.
- Simultaneous key_valid and step completion: the key's transition takes priority over the automatic RAMP_UP->RUN / RAMP_DOWN->OFF transition.

Optional Feature:
IDLE_STOP_EN:
- Defined: a 20-bit inactivity counter counts tick_en pulses while state≠OFF and clears on any accepted key.
  - At TIMEOUT_TICKS it forces RAMP_DOWN, exactly as an ONOFF key would.
  - The counter is held at 0 in OFF and on RST.
- Undefined: no counter exists; the motor runs until ONOFF is received.

Test Plan:
RAMP_DIV=4, tick_en every 2 CLK.
1. Reset, then ONOFF frame 32'h00FF45BA -> sw=1, rate_set=10, state=01; rate_set reaches 50 after 40 steps (320 CLK), then state=10, busy=0.
2. In RUN at 50, send UP ×6 -> target saturates at 100; rate_set climbs to 100; 6th UP leaves state=10 with no change.
3. Bad complement frame 32'h00FF4500 in RUN -> no change in state, target or rate_set.
4. ONOFF in RUN at 50 -> RAMP_DOWN; rate_set reaches 0 after 50 steps; sw drops to 0 one cycle later; state=00.
5. ONOFF during RAMP_DOWN at rate_set=30 -> RAMP_UP from 30 toward target 50; RST asserted mid-ramp -> all outputs return to reset values at the next edge.
6. With IDLE_STOP_EN defined and TIMEOUT_TICKS=20: start the motor, send no keys -> RAMP_DOWN entered after 20 tick_en pulses, ending in OFF with sw=0.

Source files
------------

// File: rtl/motor_ramp_ctrl.sv
// Speed sequencer between the NEC decoder and the PWM: validates key frames and slews rate_set one step at a time.
// Optional idle auto-stop is compiled in with `define IDLE_STOP_EN.
module motor_ramp_ctrl #(
  parameter logic [7:0]  KEY_ONOFF = 8'h45,
  parameter logic [7:0]  KEY_UP    = 8'h46,
  parameter logic [7:0]  KEY_DOWN  = 8'h47,
  parameter int unsigned RATE_MIN  = 10,
  parameter int unsigned RATE_MAX  = 100,
  parameter int unsigned RATE_INIT = 50,
  parameter int unsigned STEP      = 10,
  parameter int unsigned RAMP_DIV  = 100
`ifdef IDLE_STOP_EN
  ,
  parameter int unsigned TIMEOUT_TICKS = 600000
`endif
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        tick_en,
  input  logic        key_valid,
  input  logic [31:0] data_in,
  output logic [6:0]  rate_set,
  output logic        sw,
  output logic        busy,
  output logic [1:0]  state
);

  localparam int unsigned RateW = 7;
  localparam int unsigned CntW  = 10;

  typedef enum logic [1:0] {
    OFF       = 2'b00,
    RAMP_UP   = 2'b01,
    RUN       = 2'b10,
    RAMP_DOWN = 2'b11
  } stateT;

  stateT             stateQ, stateD;
  logic [RateW-1:0]  rateQ, rateD;
  logic [RateW-1:0]  targetQ, targetD;
  logic              swQ, swD;
  logic              busyQ, busyD;
  logic [CntW-1:0]   cntQ, cntD;
  logic              stepNow;
  logic              idleHit;

  logic [7:0]        cmd;
  logic              frameOk, keyOnOff, keyUp, keyDown;
  logic [7:0]        upSum;
  logic [RateW-1:0]  tgtUp, tgtDown;
  logic              unusedBits;

  assign unusedBits = ^data_in[31:16];

  // Frame decode and saturating target arithmetic
  always_comb begin
    cmd      = data_in[15:8];
    frameOk  = key_valid && (data_in[7:0] == ~cmd);
    keyOnOff = frameOk && (cmd == KEY_ONOFF);
    keyUp    = frameOk && (cmd == KEY_UP);
    keyDown  = frameOk && (cmd == KEY_DOWN);
    upSum    = 8'(targetQ) + 8'(STEP);
    tgtUp    = (upSum > 8'(RATE_MAX)) ? RateW'(RATE_MAX) : RateW'(upSum);
    tgtDown  = (8'(targetQ) < 8'(RATE_MIN + STEP)) ? RateW'(RATE_MIN)
                                                    : RateW'(8'(targetQ) - 8'(STEP));
  end

`ifdef IDLE_STOP_EN
  localparam int unsigned IdleW = 20;
  logic [IdleW-1:0] idleQ;

  assign idleHit = tick_en && (idleQ == IdleW'(TIMEOUT_TICKS - 1));

  // Inactivity timer: runs only while the motor is on, cleared by any accepted key
  always_ff @(posedge CLK) begin
    if (RST) begin
      idleQ <= '0;
    end else if (stateQ == OFF || keyOnOff || keyUp || keyDown || idleHit) begin
      idleQ <= '0;
    end else if (tick_en) begin
      idleQ <= idleQ + IdleW'(1);
    end
  end
`else
  assign idleHit = 1'b0;
`endif

  // Next-state, ramp engine and output decode
  always_comb begin
    stateD  = stateQ;
    rateD   = rateQ;
    targetD = targetQ;
    swD     = swQ;
    cntD    = '0;
    stepNow = 1'b0;

    if (stateQ == RAMP_UP || stateQ == RAMP_DOWN) begin
      cntD = cntQ;
      if (tick_en) begin
        if (cntQ == CntW'(RAMP_DIV - 1)) begin
          cntD    = '0;
          stepNow = 1'b1;
        end else begin
          cntD = cntQ + CntW'(1);
        end
      end
    end

    if (stepNow) begin
      if (stateQ == RAMP_DOWN) begin
        if (rateQ != '0) rateD = rateQ - RateW'(1);
      end else if (rateQ < targetQ) begin
        rateD = rateQ + RateW'(1);
      end else if (rateQ > targetQ) begin
        rateD = rateQ - RateW'(1);
      end
    end

    // Key actions take priority over the automatic end-of-ramp transitions
    case (stateQ)
      OFF: begin
        if (keyOnOff) begin
          stateD = RAMP_UP;
          swD    = 1'b1;
          rateD  = RateW'(RATE_MIN);
        end
      end
      RAMP_UP: begin
        if (keyOnOff || idleHit) stateD = RAMP_DOWN;
        else if (keyUp)          targetD = tgtUp;
        else if (keyDown)        targetD = tgtDown;
        else if (rateQ == targetQ) stateD = RUN;
      end
      RUN: begin
        if (keyOnOff || idleHit) begin
          stateD = RAMP_DOWN;
        end else if (keyUp && tgtUp != targetQ) begin
          targetD = tgtUp;
          stateD  = RAMP_UP;
        end else if (keyDown && tgtDown != targetQ) begin
          targetD = tgtDown;
          stateD  = RAMP_UP;
        end
      end
      RAMP_DOWN: begin
        if (keyOnOff) begin
          stateD = RAMP_UP;
          if (rateD < RateW'(RATE_MIN)) rateD = RateW'(RATE_MIN);
        end else if (rateQ == '0) begin
          stateD = OFF;
          swD    = 1'b0;
        end
      end
      default: stateD = OFF;
    endcase

    if (stateD != RAMP_UP && stateD != RAMP_DOWN) cntD = '0;
    busyD = (stateD == RAMP_UP) || (stateD == RAMP_DOWN);
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      stateQ  <= OFF;
      rateQ   <= '0;
      targetQ <= RateW'(RATE_INIT);
      swQ     <= 1'b0;
      busyQ   <= 1'b0;
      cntQ    <= '0;
    end else begin
      stateQ  <= stateD;
      rateQ   <= rateD;
      targetQ <= targetD;
      swQ     <= swD;
      busyQ   <= busyD;
      cntQ    <= cntD;
    end
  end

  assign rate_set = rateQ;
  assign sw       = swQ;
  assign busy     = busyQ;
  assign state    = stateQ;

endmodule

// File: tb/tb_motor_ramp_ctrl.sv
// Directed bench for motor_ramp_ctrl with RAMP_DIV=4 and tick_en every second clock.
// With IDLE_STOP_EN defined it exercises only the idle auto-stop path (TIMEOUT_TICKS=20).
module tb_motor_ramp_ctrl;

  logic        CLK = 1'b0;
  logic        RST;
  logic        tick_en;
  logic        key_valid;
  logic [31:0] data_in;
  logic [6:0]  rate_set;
  logic        sw;
  logic        busy;
  logic [1:0]  state;

  int passCnt  = 0;
  int totalCnt = 0;
  int failCnt  = 0;
  int badStep  = 0;
  int n;

  localparam logic [31:0] F_ONOFF = 32'h00FF45BA;
  localparam logic [31:0] F_UP    = 32'h00FF46B9;
  localparam logic [31:0] F_DOWN  = 32'h00FF47B8;
  localparam logic [31:0] F_BAD   = 32'h00FF4500;
  localparam logic [31:0] F_UNK   = 32'h00FF48B7;

  motor_ramp_ctrl #(
    .RAMP_DIV(4)
`ifdef IDLE_STOP_EN
    ,
    .TIMEOUT_TICKS(20)
`endif
  ) dut (
    .CLK(CLK),
    .RST(RST),
    .tick_en(tick_en),
    .key_valid(key_valid),
    .data_in(data_in),
    .rate_set(rate_set),
    .sw(sw),
    .busy(busy),
    .state(state)
  );

  always #5 CLK = ~CLK;

  initial begin
    tick_en = 1'b0;
    forever begin
      @(negedge CLK);
      tick_en = ~tick_en;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    totalCnt++;
    assert (obs === exp) passCnt++;
    else begin
      failCnt++;
      $error("FAIL %s: observed %0d expected %0d (failure #%0d)", tag, obs, exp, failCnt);
    end
  endtask

  task automatic cyc(input int k);
    repeat (k) @(negedge CLK);
  endtask

  // Called at a negedge; returns at the negedge after the accepting edge
  task automatic sendKey(input logic [31:0] f);
    key_valid = 1'b1;
    data_in   = f;
    @(negedge CLK);
    key_valid = 1'b0;
    data_in   = '0;
  endtask

  // Waits for rate_set==goal, flagging any jump larger than 1 or overshoot above 100
  task automatic waitRate(input int goal, input int budget, output int cycles);
    int p;
    int r;
    p = int'(rate_set);
    cycles = 0;
    while (int'(rate_set) != goal && cycles < budget) begin
      @(negedge CLK);
      cycles++;
      r = int'(rate_set);
      if (r > p + 1 || p > r + 1 || r > 100) badStep++;
      p = r;
    end
  endtask

  initial begin
    RST       = 1'b1;
    key_valid = 1'b0;
    data_in   = '0;
    cyc(3);
    chk("rst_rate", 32'(rate_set), 0);
    chk("rst_sw",   32'(sw),       0);
    chk("rst_busy", 32'(busy),     0);
    chk("rst_state", 32'(state),   0);
    RST = 1'b0;
    cyc(2);

`ifdef IDLE_STOP_EN
    sendKey(F_ONOFF);
    chk("idle_start_state", 32'(state), 1);
    n = 0;
    while (state != 2'b11 && n < 100) begin
      @(negedge CLK);
      n++;
    end
    chk("idle_rampdown_state", 32'(state), 3);
    chk("idle_rampdown_time", 32'(n >= 36 && n <= 44), 1);
    chk("idle_rampdown_sw", 32'(sw), 1);
    waitRate(0, 400, n);
    chk("idle_rate_zero", 32'(rate_set), 0);
    cyc(1);
    chk("idle_off_state", 32'(state), 0);
    chk("idle_off_sw", 32'(sw), 0);
`else
    // Soft start from OFF to the initial target of 50
    sendKey(F_ONOFF);
    chk("t1_state", 32'(state), 1);
    chk("t1_rate",  32'(rate_set), 10);
    chk("t1_sw",    32'(sw), 1);
    chk("t1_busy",  32'(busy), 1);
    waitRate(50, 400, n);
    chk("t1_reach50", 32'(rate_set), 50);
    chk("t1_time", 32'(n >= 316 && n <= 324), 1);
    cyc(1);
    chk("t1_run_state", 32'(state), 2);
    chk("t1_run_busy",  32'(busy), 0);
    chk("t1_run_rate",  32'(rate_set), 50);

    // Speed up to saturation at 100
    sendKey(F_UP);
    chk("t2_state_up", 32'(state), 1);
    for (int i = 0; i < 4; i++) sendKey(F_UP);
    waitRate(100, 600, n);
    chk("t2_reach100", 32'(rate_set), 100);
    cyc(1);
    chk("t2_run", 32'(state), 2);
    sendKey(F_UP);
    chk("t2_sat_state", 32'(state), 2);
    chk("t2_sat_busy",  32'(busy), 0);
    cyc(10);
    chk("t2_sat_rate", 32'(rate_set), 100);

    // Rejected frames leave everything alone
    sendKey(F_BAD);
    chk("t3_bad_state", 32'(state), 2);
    chk("t3_bad_rate",  32'(rate_set), 100);
    sendKey(F_UNK);
    chk("t3_unk_state", 32'(state), 2);
    data_in = F_ONOFF;
    cyc(1);
    data_in = '0;
    chk("t3_novalid_state", 32'(state), 2);
    sendKey(F_DOWN);
    chk("t3_down_state", 32'(state), 1);
    for (int i = 0; i < 4; i++) sendKey(F_DOWN);
    waitRate(50, 600, n);
    chk("t3_reach50", 32'(rate_set), 50);
    cyc(1);
    chk("t3_run", 32'(state), 2);

    // Soft stop from 50 and gated switch-off
    sendKey(F_ONOFF);
    chk("t4_state", 32'(state), 3);
    chk("t4_sw",    32'(sw), 1);
    chk("t4_busy",  32'(busy), 1);
    chk("t4_rate",  32'(rate_set), 50);
    waitRate(0, 600, n);
    chk("t4_reach0", 32'(rate_set), 0);
    chk("t4_time", 32'(n >= 396 && n <= 404), 1);
    chk("t4_zero_state", 32'(state), 3);
    chk("t4_zero_sw",    32'(sw), 1);
    cyc(1);
    chk("t4_off_state", 32'(state), 0);
    chk("t4_off_sw",    32'(sw), 0);
    chk("t4_off_busy",  32'(busy), 0);

    // Reverse a ramp-down, saturate target low, then reset mid-ramp
    sendKey(F_ONOFF);
    waitRate(50, 400, n);
    cyc(1);
    chk("t5_run", 32'(state), 2);
    sendKey(F_ONOFF);
    chk("t5_down", 32'(state), 3);
    waitRate(30, 300, n);
    chk("t5_at30", 32'(rate_set), 30);
    sendKey(F_ONOFF);
    chk("t5_rev_state", 32'(state), 1);
    chk("t5_rev_rate",  32'(rate_set), 30);
    chk("t5_rev_sw",    32'(sw), 1);
    waitRate(31, 20, n);
    chk("t5_climb", 32'(rate_set), 31);
    for (int i = 0; i < 6; i++) sendKey(F_DOWN);
    waitRate(10, 300, n);
    chk("t5_reach10", 32'(rate_set), 10);
    cyc(1);
    chk("t5_run_min", 32'(state), 2);
    sendKey(F_DOWN);
    chk("t5_min_sat_state", 32'(state), 2);
    chk("t5_min_sat_rate",  32'(rate_set), 10);
    sendKey(F_UP);
    chk("t5_up_state", 32'(state), 1);
    cyc(10);
    RST = 1'b1;
    cyc(1);
    chk("t5_rst_rate",  32'(rate_set), 0);
    chk("t5_rst_sw",    32'(sw), 0);
    chk("t5_rst_busy",  32'(busy), 0);
    chk("t5_rst_state", 32'(state), 0);
    RST = 1'b0;
    cyc(1);
    sendKey(F_ONOFF);
    chk("t5_restart_rate", 32'(rate_set), 10);
    waitRate(50, 400, n);
    cyc(1);
    chk("t5_target_reset_rate",  32'(rate_set), 50);
    chk("t5_target_reset_state", 32'(state), 2);
`endif

    chk("single_steps", 32'(badStep), 0);
    $display("%0d/%0d checks passed", passCnt, totalCnt);
    $finish;
  end

endmodule
